// File: rtl/uart_rx_getc.sv
// uart_rx_getc: 8N1 UART receiver feeding a show-ahead FIFO behind a getc handshake.
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   rx        serial input, idles high
//   getc_en   FIFO non-empty, getc_char valid
//   getc_char head-of-FIFO byte, 0 when empty
//   getc_pop  remove head byte this edge (ignored when empty)
//   level     bytes stored
//   overflow  sticky, a received byte was dropped on a full FIFO
//   frame_err one-cycle pulse on a bad stop bit
//   rx_busy   receiver not idle
module uart_rx_getc #(
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  output logic                          getc_en,
  output logic [7:0]                    getc_char,
  input  logic                          getc_pop,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          frame_err,
  output logic                          rx_busy
);
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(DIV - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  state_t          r_state, w_next;
  logic            r_sync1, r_sync2;
  logic            w_rxs, w_tick, w_push, w_pop, w_acc;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_rd, r_wr;
  assign w_rxs  = r_sync2;
  assign w_tick = r_cnt == '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) {r_sync1, r_sync2} <= 2'b11;
    else      {r_sync1, r_sync2} <= {rx, r_sync1};
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = w_rxs ? IDLE : START;
      START:     w_next = w_tick ? (w_rxs ? IDLE : DATA) : START;
      DATA:      w_next = (w_tick && r_bit == 3'd7) ? STOP : DATA;
      STOP:      w_next = w_tick ? (w_rxs ? IDLE : WAIT_HIGH) : STOP;
      WAIT_HIGH: w_next = w_rxs ? IDLE : WAIT_HIGH;
      default:   w_next = IDLE;
    endcase
  end
  always_comb begin
    w_push    = r_state == STOP && w_tick && w_rxs;
    frame_err = r_state == STOP && w_tick && !w_rxs;
    rx_busy   = r_state != IDLE;
  end
  // IDLE keeps the counter preloaded with the half-bit delay so START
  // samples mid start bit; every later sample reloads a full bit period.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_cnt <= (r_state == IDLE) ? HALF : (w_tick ? FULL : r_cnt - CW'(1));
      if (r_state == START) r_bit <= '0;
      else if (r_state == DATA && w_tick) begin
        r_bit   <= r_bit + 3'd1;
        r_shift <= {w_rxs, r_shift[7:1]};
      end
    end
  assign getc_en   = level != '0;
  assign getc_char = getc_en ? r_mem[r_rd] : 8'h00;
  assign w_pop     = getc_pop && getc_en;
  // a full FIFO still accepts the byte when the head leaves in the same cycle
  assign w_acc     = w_push && (level != LW'(FIFO_DEPTH) || w_pop);
  always_ff @(posedge clk)
    if (w_acc) r_mem[r_wr] <= r_shift;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_rd     <= '0;
      r_wr     <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      r_wr     <= r_wr + AW'(w_acc);
      r_rd     <= r_rd + AW'(w_pop);
      level    <= level + LW'(w_acc) - LW'(w_pop);
      overflow <= overflow | (w_push & ~w_acc);
    end
endmodule

// File: tb/tb_uart_rx_getc.sv
// tb_uart_rx_getc: directed table-driven bench for uart_rx_getc (DIV=16, FIFO_DEPTH=4).
module tb_uart_rx_getc;
  logic       clk = 1'b0, rst = 1'b0, rx = 1'b1, getc_pop = 1'b0;
  logic       getc_en, overflow, frame_err, rx_busy;
  logic [7:0] getc_char;
  logic [2:0] level;
  int n_cmp = 0, n_bad = 0, n_ferr = 0;
  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         pops;
    logic [2:0] lvl;
    logic [7:0] head;
    logic       ovf;
    int         ferr;
  } vec_t;
  vec_t tv [10];
  uart_rx_getc #(.CLK_FREQ(16), .BAUD(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rx(rx), .getc_en(getc_en), .getc_char(getc_char),
    .getc_pop(getc_pop), .level(level), .overflow(overflow),
    .frame_err(frame_err), .rx_busy(rx_busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (frame_err === 1'b1) n_ferr++;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // start bit plus 8 data bits, 16 cycles each; returns just after the
  // edge where the stop bit begins (stop sample lands 11 edges later)
  task automatic send_head(input logic [7:0] b);
    @(posedge clk); #1 rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (16) @(posedge clk);
      #1 rx = b[i];
    end
    repeat (16) @(posedge clk);
    #1;
  endtask
  task automatic send_byte(input logic [7:0] b);
    send_head(b);
    rx = 1'b1;
    repeat (16) @(posedge clk);
    #1;
  endtask
  task automatic pop_list(input logic [31:0] exp, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("pop_head", {24'h0, getc_char}, {24'h0, exp[8*k +: 8]});
      getc_pop = 1'b1;
    end
    @(negedge clk);
    getc_pop = 1'b0;
    chk("pop_empty_en", {31'h0, getc_en}, 32'h0);
    chk("pop_empty_lvl", {29'h0, level}, 32'h0);
  endtask
  task automatic apply_vec(input vec_t v);
    n_ferr = 0;
    if (v.stop) send_byte(v.data);
    else begin
      send_head(v.data);
      rx = 1'b0;
      repeat (40) @(posedge clk);
      @(negedge clk);
      chk("wait_high_busy", {31'h0, rx_busy}, 32'h1);
      rx = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("wait_high_exit", {31'h0, rx_busy}, 32'h0);
    end
    for (int k = 0; k < v.pops; k++) begin
      @(negedge clk); getc_pop = 1'b1;
      @(posedge clk); #1 getc_pop = 1'b0;
    end
    @(negedge clk);
    chk("vec_level", {29'h0, level}, {29'h0, v.lvl});
    chk("vec_head", {24'h0, getc_char}, {24'h0, v.head});
    chk("vec_en", {31'h0, getc_en}, {31'h0, v.lvl != 3'd0});
    chk("vec_ovf", {31'h0, overflow}, {31'h0, v.ovf});
    chk("vec_ferr", n_ferr, v.ferr);
  endtask
  initial begin
    tv[0] = '{8'h33, 1'b1, 0, 3'd1, 8'h33, 1'b0, 0};
    tv[1] = '{8'h66, 1'b1, 0, 3'd2, 8'h33, 1'b0, 0};
    tv[2] = '{8'h04, 1'b1, 0, 3'd3, 8'h33, 1'b0, 0};
    tv[3] = '{8'h5A, 1'b0, 0, 3'd0, 8'h00, 1'b0, 1};
    tv[4] = '{8'h55, 1'b1, 0, 3'd1, 8'h55, 1'b0, 0};
    tv[5] = '{8'h10, 1'b1, 1, 3'd1, 8'h10, 1'b0, 0};
    tv[6] = '{8'h11, 1'b1, 0, 3'd2, 8'h10, 1'b0, 0};
    tv[7] = '{8'h12, 1'b1, 0, 3'd3, 8'h10, 1'b0, 0};
    tv[8] = '{8'h13, 1'b1, 0, 3'd4, 8'h10, 1'b0, 0};
    tv[9] = '{8'h14, 1'b1, 0, 3'd4, 8'h10, 1'b1, 0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_en", {31'h0, getc_en}, 32'h0);
    chk("rst_char", {24'h0, getc_char}, 32'h0);
    chk("rst_level", {29'h0, level}, 32'h0);
    chk("rst_ovf", {31'h0, overflow}, 32'h0);
    chk("rst_ferr", {31'h0, frame_err}, 32'h0);
    chk("rst_busy", {31'h0, rx_busy}, 32'h0);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    // single byte with exact latency; a pop on the push cycle into an empty FIFO is ignored
    send_head(8'h41);
    rx = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("lat_before", {31'h0, getc_en}, 32'h0);
    getc_pop = 1'b1;
    @(posedge clk); #1 getc_pop = 1'b0;
    @(negedge clk);
    chk("lat_en", {31'h0, getc_en}, 32'h1);
    chk("lat_char", {24'h0, getc_char}, 32'h41);
    chk("lat_level", {29'h0, level}, 32'h1);
    getc_pop = 1'b1;
    @(posedge clk); #1 getc_pop = 1'b0;
    @(negedge clk);
    chk("pop1_en", {31'h0, getc_en}, 32'h0);
    chk("pop1_char", {24'h0, getc_char}, 32'h0);
    chk("pop1_level", {29'h0, level}, 32'h0);
    repeat (10) @(posedge clk);
    for (int i = 0; i < 3; i++) apply_vec(tv[i]);
    pop_list(32'h0004_6633, 3);
    // glitch shorter than half a bit
    n_ferr = 0;
    @(posedge clk); #1 rx = 1'b0;
    repeat (5) @(posedge clk);
    #1 rx = 1'b1;
    @(negedge clk);
    chk("glitch_start", {31'h0, rx_busy}, 32'h1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("glitch_idle", {31'h0, rx_busy}, 32'h0);
    chk("glitch_level", {29'h0, level}, 32'h0);
    chk("glitch_ferr", n_ferr, 0);
    for (int i = 3; i < 10; i++) apply_vec(tv[i]);
    pop_list(32'h1312_1110, 4);
    chk("ovf_sticky", {31'h0, overflow}, 32'h1);
    // full FIFO with a pop on the 5th push cycle
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("rst2_ovf", {31'h0, overflow}, 32'h0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i));
    @(negedge clk);
    chk("full_level", {29'h0, level}, 32'h4);
    send_head(8'h14);
    rx = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk); getc_pop = 1'b1;
    @(posedge clk); #1 getc_pop = 1'b0;
    @(negedge clk);
    chk("pushpop_level", {29'h0, level}, 32'h4);
    chk("pushpop_head", {24'h0, getc_char}, 32'h11);
    chk("pushpop_ovf", {31'h0, overflow}, 32'h0);
    repeat (10) @(posedge clk);
    pop_list(32'h1413_1211, 4);
    // asynchronous reset in the middle of a frame with two bytes stored
    send_byte(8'h01);
    send_byte(8'h02);
    @(negedge clk);
    chk("pre_rst_level", {29'h0, level}, 32'h2);
    @(posedge clk); #1 rx = 1'b0;
    repeat (40) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_en", {31'h0, getc_en}, 32'h0);
    chk("arst_level", {29'h0, level}, 32'h0);
    chk("arst_busy", {31'h0, rx_busy}, 32'h0);
    rx = 1'b1;
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("post_rst_level", {29'h0, level}, 32'h0);
    n_ferr = 0;
    send_byte(8'hA5);
    @(negedge clk);
    chk("a5_level", {29'h0, level}, 32'h1);
    chk("a5_char", {24'h0, getc_char}, 32'hA5);
    chk("a5_ferr", n_ferr, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
